// File: rtl/pacote_matriz.sv
// ============================================================================
// Module      : pacote_matriz (package)
// Description : Shared constants for the 5x7 cursor matrix. The coordinate
//               width, matrix limits and direction encoding are the same
//               ones used by modulo_seletor_1_8 and the display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pacote_matriz;

  // Matrix geometry: columns 0..4, lines 0..6, 3-bit coordinates.
  localparam int MAT_COL_MAX = 4;
  localparam int MAT_ROW_MAX = 6;
  localparam int COORD_W     = 3;

  // Direction encoding doubles as the bit index of each button's press
  // vector. A lower index means a higher priority.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // One wrapping step on a coordinate. The wrap is compare-based, so the
  // result never leaves 0..max even though the arithmetic is 3-bit.
  function automatic logic [COORD_W-1:0] passo_circular(
    input logic [COORD_W-1:0] valor,
    input logic               incrementa,
    input logic [COORD_W-1:0] maximo
  );
    logic [COORD_W-1:0] res;
    if (incrementa) begin
      res = (valor == maximo) ? '0 : valor + 1'b1;
    end else begin
      res = (valor == '0) ? maximo : valor - 1'b1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debouncer_botao.sv
// ============================================================================
// Module      : debouncer_botao
// Description : One push-button front end: two-flop synchroniser,
//               consecutive-sample debounce counter, stable level and a
//               one-cycle press pulse on each accepted 0->1 transition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer_botao #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW     = 4;
  localparam logic [CW-1:0] c_last = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
  // samples; any matching sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 != r_stable) begin
      if (r_cnt == c_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered rising-edge detector on the stable level: one pulse per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
    end
  end

  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/modulo_posicao_cursor.sv
// ============================================================================
// Module      : modulo_posicao_cursor
// Description : Converts four raw push-buttons into the registered cursor
//               position (mdc column, mdl line) with wrap-around on the 5x7
//               matrix and a one-cycle move strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modulo_posicao_cursor
  import pacote_matriz::*;
#(
  parameter int COL_MAX         = MAT_COL_MAX,
  parameter int ROW_MAX         = MAT_ROW_MAX,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               hold,
  output logic [COORD_W-1:0] mdc,
  output logic [COORD_W-1:0] mdl,
  output logic               mov_valid
);

  localparam logic [COORD_W-1:0] c_col_max = COORD_W'(COL_MAX);
  localparam logic [COORD_W-1:0] c_row_max = COORD_W'(ROW_MAX);

  logic [3:0]         w_btn;
  logic [3:0]         w_press;
  logic               w_move;
  dir_t               w_dir;
  logic [COORD_W-1:0] r_mdc;
  logic [COORD_W-1:0] r_mdl;
  logic               r_mov;

  // Bit order follows the direction encoding.
  assign w_btn = {btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_debounce
    debouncer_botao #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_btn[g]),
      .o_press(w_press[g])
    );
  end

  // Fixed-priority select of a single direction; losing presses are simply
  // dropped because each pulse lasts only one cycle.
  always_comb begin
    w_move = 1'b0;
    w_dir  = DIR_UP;
    if (w_press[int'(DIR_UP)]) begin
      w_move = 1'b1;
      w_dir  = DIR_UP;
    end else if (w_press[int'(DIR_DOWN)]) begin
      w_move = 1'b1;
      w_dir  = DIR_DOWN;
    end else if (w_press[int'(DIR_LEFT)]) begin
      w_move = 1'b1;
      w_dir  = DIR_LEFT;
    end else if (w_press[int'(DIR_RIGHT)]) begin
      w_move = 1'b1;
      w_dir  = DIR_RIGHT;
    end
  end

  // Position registers and move strobe; hold swallows the press outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mdc <= '0;
      r_mdl <= '0;
      r_mov <= 1'b0;
    end else begin
      r_mov <= 1'b0;
      if (w_move && !hold) begin
        r_mov <= 1'b1;
        unique case (w_dir)
          DIR_UP:    r_mdl <= passo_circular(r_mdl, 1'b0, c_row_max);
          DIR_DOWN:  r_mdl <= passo_circular(r_mdl, 1'b1, c_row_max);
          DIR_LEFT:  r_mdc <= passo_circular(r_mdc, 1'b0, c_col_max);
          DIR_RIGHT: r_mdc <= passo_circular(r_mdc, 1'b1, c_col_max);
        endcase
      end
    end
  end

  assign mdc       = r_mdc;
  assign mdl       = r_mdl;
  assign mov_valid = r_mov;

endmodule

`default_nettype wire

// File: tb/tb_modulo_posicao_cursor.sv
// ============================================================================
// Module      : tb_modulo_posicao_cursor
// Description : Self-checking bench for modulo_posicao_cursor with directed
//               scenarios and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modulo_posicao_cursor;

  localparam int N_DEB = 4;
  localparam int C_MAX = 4;
  localparam int R_MAX = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] mdc;
  logic [2:0] mdl;
  logic       mov_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int n_mov    = 0;
  int cyc      = 0;

  // Reference model state: raw-sample history (index 0 = previous edge),
  // accepted level and the edge at which an accepted press becomes a move.
  logic hist [4][0:15];
  logic m_stab [4];
  int   m_due [4];
  int   exp_mdc = 0;
  int   exp_mdl = 0;
  logic exp_mov = 1'b0;

  modulo_posicao_cursor #(
    .COL_MAX(C_MAX),
    .ROW_MAX(R_MAX),
    .DEBOUNCE_CYCLES(N_DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .hold(hold),
    .mdc(mdc),
    .mdl(mdl),
    .mov_valid(mov_valid)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, update the reference model, then settle.
  task automatic step();
    logic raw [4];
    logic all_diff;
    int   win;
    @(posedge clk);
    raw[0] = btn_up;
    raw[1] = btn_down;
    raw[2] = btn_left;
    raw[3] = btn_right;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        m_stab[b] = 1'b0;
        m_due[b]  = -1;
        for (int k = 0; k < 16; k++) hist[b][k] = 1'b0;
      end
      exp_mdc = 0;
      exp_mdl = 0;
      exp_mov = 1'b0;
    end else begin
      win = -1;
      for (int b = 3; b >= 0; b--) begin
        if (m_due[b] == cyc) begin
          win      = b;
          m_due[b] = -1;
        end
      end
      exp_mov = 1'b0;
      if (win >= 0 && !hold) begin
        exp_mov = 1'b1;
        case (win)
          0: exp_mdl = (exp_mdl == 0) ? R_MAX : exp_mdl - 1;
          1: exp_mdl = (exp_mdl == R_MAX) ? 0 : exp_mdl + 1;
          2: exp_mdc = (exp_mdc == 0) ? C_MAX : exp_mdc - 1;
          default: exp_mdc = (exp_mdc == C_MAX) ? 0 : exp_mdc + 1;
        endcase
      end
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= N_DEB; k++) begin
          if (hist[b][k] == m_stab[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stab[b] = ~m_stab[b];
          if (m_stab[b]) m_due[b] = cyc + 2;
        end
        for (int k = 15; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = raw[b];
      end
    end
    cyc++;
    #1;
    if (mov_valid === 1'b1) n_mov++;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    repeat (8) step();
    set_btn(b, 1'b0);
    repeat (8) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_checks++;
    if (mdc !== 3'd0 || mdl !== 3'd0 || mov_valid !== 1'b0)
      $display("FAIL reset: mdc=%0d mdl=%0d mov=%b required 0 0 0", mdc, mdl, mov_valid);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int m0;
    m0 = n_mov;
    btn_right = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      n_checks++;
      if (mdc !== ((e >= 7) ? 3'd1 : 3'd0) || mdl !== 3'd0)
        $display("FAIL latency_pos edge %0d: mdc=%0d mdl=%0d required %0d 0", e, mdc, mdl, (e >= 7) ? 1 : 0);
      else n_pass++;
      n_checks++;
      if (mov_valid !== (e == 7))
        $display("FAIL latency_mov edge %0d: mov=%b required %b", e, mov_valid, (e == 7));
      else n_pass++;
    end
    btn_right = 1'b0;
    repeat (10) step();
    n_checks++;
    if (n_mov - m0 != 1) $display("FAIL latency_count: moves=%0d required 1", n_mov - m0);
    else n_pass++;
  endtask

  task automatic test_right_wrap();
    int exp_seq [5];
    exp_seq = '{1, 2, 3, 4, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press_btn(3);
      n_checks++;
      if (mdc !== 3'(exp_seq[i]))
        $display("FAIL right_wrap press %0d: mdc=%0d required %0d", i, mdc, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_up_down_wrap();
    press_btn(0);
    n_checks++;
    if (mdl !== 3'd6) $display("FAIL up_wrap: mdl=%0d required 6", mdl);
    else n_pass++;
    press_btn(1);
    n_checks++;
    if (mdl !== 3'd0) $display("FAIL down_wrap: mdl=%0d required 0", mdl);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int m0;
    logic [2:0] l0;
    m0 = n_mov;
    l0 = mdl;
    for (int r = 0; r < 2; r++) begin
      btn_down = 1'b1;
      repeat (3) step();
      btn_down = 1'b0;
      repeat (2) step();
    end
    repeat (10) step();
    n_checks++;
    if (mdl !== l0 || n_mov != m0)
      $display("FAIL glitch: mdl=%0d moves=%0d required mdl=%0d moves=0", mdl, n_mov - m0, l0);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (3) press_btn(1);
    repeat (2) press_btn(3);
    n_checks++;
    if (mdl !== 3'd3 || mdc !== 3'd2) $display("FAIL simul_setup: mdl=%0d mdc=%0d required 3 2", mdl, mdc);
    else n_pass++;
    btn_up   = 1'b1;
    btn_left = 1'b1;
    repeat (8) step();
    n_checks++;
    if (mdl !== 3'd2 || mdc !== 3'd2 || mov_valid !== 1'b1)
      $display("FAIL simul_edge7: mdl=%0d mdc=%0d mov=%b required 2 2 1", mdl, mdc, mov_valid);
    else n_pass++;
    repeat (10) step();
    n_checks++;
    if (mdl !== 3'd2 || mdc !== 3'd2) $display("FAIL simul_held: mdl=%0d mdc=%0d required 2 2", mdl, mdc);
    else n_pass++;
    btn_up   = 1'b0;
    btn_left = 1'b0;
    repeat (8) step();
    press_btn(2);
    n_checks++;
    if (mdl !== 3'd2 || mdc !== 3'd1) $display("FAIL simul_repress: mdl=%0d mdc=%0d required 2 1", mdl, mdc);
    else n_pass++;
  endtask

  task automatic test_hold();
    int m0;
    logic [2:0] c0;
    m0 = n_mov;
    c0 = mdc;
    hold = 1'b1;
    press_btn(3);
    hold = 1'b0;
    repeat (6) step();
    n_checks++;
    if (mdc !== c0 || n_mov != m0)
      $display("FAIL hold: mdc=%0d moves=%0d required mdc=%0d moves=0", mdc, n_mov - m0, c0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_left = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      step();
      n_checks++;
      if (mdc !== 3'd0 || mdl !== 3'd0)
        $display("FAIL rst_mid_during %0d: mdc=%0d mdl=%0d required 0 0", e, mdc, mdl);
      else n_pass++;
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      n_checks++;
      if (mdc !== ((e == 7) ? 3'd4 : 3'd0) || mov_valid !== (e == 7))
        $display("FAIL rst_mid_after edge %0d: mdc=%0d mov=%b required %0d %b",
                 e, mdc, mov_valid, (e == 7) ? 4 : 0, (e == 7));
      else n_pass++;
    end
    btn_left = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) btn_up    = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down  = ~btn_down;
      if ($urandom_range(0, 5) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
      hold = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
      n_checks++;
      if (int'(mdc) !== exp_mdc || int'(mdl) !== exp_mdl || mov_valid !== exp_mov)
        $display("FAIL random cycle %0d: mdc=%0d mdl=%0d mov=%b required %0d %0d %b",
                 i, mdc, mdl, mov_valid, exp_mdc, exp_mdl, exp_mov);
      else n_pass++;
    end
    rst = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      m_stab[b] = 1'b0;
      m_due[b]  = -1;
      for (int k = 0; k < 16; k++) hist[b][k] = 1'b0;
    end
    test_reset();
    test_latency();
    test_right_wrap();
    test_up_down_wrap();
    test_glitch();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
